// File: rtl/sram_pkg.sv
// Shared types and helpers for the banked single-port SRAM subsystem.
package sram_pkg;

  // Controller state: zero-init sweep, then normal request service.
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Default geometry of the subsystem.
  localparam int DEF_DEPTH = 512;
  localparam int DEF_BANKS = 2;
  localparam int ROWS      = DEF_DEPTH / DEF_BANKS;

  // Number of address bits that select a bank; a single bank needs none.
  function automatic int bank_bits(input int banks);
    return (banks <= 1) ? 0 : $clog2(banks);
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One bank: ROWS x DATA_W single-port RAM with a bit-masked write and a
// registered (1-cycle) read. Stand-in for the foundry macro in ASIC builds.
module sram_bank #(
  parameter int DATA_W = 64,
  parameter int ROWS   = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_wmask,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [ROWS];
  logic [DATA_W-1:0] r_rdata;

  // Masked write or registered read of the addressed row when enabled.
  // NOTE: the array has no reset on purpose - a RAM macro cannot be reset, and
  // contents are expected to survive a reset when zero-init is disabled.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= (i_wdata & i_wmask) | (r_mem[i_addr] & ~i_wmask);
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_banked_1rw.sv
// Banked single-port SRAM: interleaved banks behind one valid/ready port,
// masked writes, zero-init sweep after reset and a 1- or 2-cycle read path.
module sram_banked_1rw
  import sram_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BANKS     = DEF_BANKS,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done
);

  localparam int BANK_W = bank_bits(BANKS);
  localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam int N_ROWS = DEPTH / BANKS;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROW_W-1:0]  r_init_row;
  logic [ROW_W-1:0]  w_init_row_nxt;
  logic              w_init_wr;
  logic              w_accept;

  logic [SEL_W-1:0]  w_bank;
  logic [ROW_W-1:0]  w_row;
  logic [BANKS-1:0]  w_bank_en;
  logic              w_bank_we;
  logic [ROW_W-1:0]  w_bank_addr;
  logic [DATA_W-1:0] w_bank_wdata;
  logic [DATA_W-1:0] w_bank_wmask;
  logic [DATA_W-1:0] w_bank_rdata [BANKS];
  logic [DATA_W-1:0] w_mux;

  logic              r_p1_valid;
  logic [SEL_W-1:0]  r_p1_bank;

  // State register and init row counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking assignments here would create order races.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_INIT;
      r_init_row <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_row <= w_init_row_nxt;
    end
  end

  // Next-state logic, init sweep control and port handshake.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_row_nxt = r_init_row;
    w_init_wr      = 1'b0;
    w_accept       = 1'b0;
    req_ready      = 1'b0;
    init_done      = 1'b0;
    case (r_state)
      S_INIT: begin
        if (INIT_ZERO != 0) begin
          w_init_wr      = 1'b1;
          w_init_row_nxt = r_init_row + 1'b1;
          if (r_init_row == ROW_W'(N_ROWS - 1)) begin
            w_state_nxt    = S_RUN;
            w_init_row_nxt = '0;
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        w_accept  = req_valid;
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Low address bits select the bank, the rest select the row.
  generate
    if (BANK_W > 0) begin : g_bank_sel
      assign w_bank = req_addr[BANK_W-1:0];
    end else begin : g_single_bank
      assign w_bank = '0;
    end
  endgenerate

  assign w_row = ROW_W'(req_addr >> BANK_W);

  // Bank enables: all banks during the init sweep, else only the addressed one on accept.
  always_comb begin
    w_bank_en = '0;
    for (int b = 0; b < BANKS; b++) begin
      w_bank_en[b] = w_init_wr | (w_accept & (w_bank == SEL_W'(b)));
    end
  end

  assign w_bank_we    = w_init_wr | req_write;
  assign w_bank_addr  = w_init_wr ? r_init_row : w_row;
  assign w_bank_wdata = w_init_wr ? '0 : req_wdata;
  assign w_bank_wmask = w_init_wr ? '1 : req_wmask;

  generate
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
      sram_bank #(
        .DATA_W (DATA_W),
        .ROWS   (N_ROWS),
        .ADDR_W (ROW_W)
      ) u_bank (
        .i_clk   (CLK),
        .i_en    (w_bank_en[g]),
        .i_we    (w_bank_we),
        .i_addr  (w_bank_addr),
        .i_wdata (w_bank_wdata),
        .i_wmask (w_bank_wmask),
        .o_rdata (w_bank_rdata[g])
      );
    end
  endgenerate

  // First read stage: valid flag plus the bank tag that steers the output mux.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_p1_valid <= 1'b0;
      r_p1_bank  <= '0;
    end else begin
      r_p1_valid <= w_accept & ~req_write;
      if (w_accept && !req_write) begin
        r_p1_bank <= w_bank;
      end
    end
  end

  // The tag only moves on an accepted read and bank read registers only change
  // on reads, so the mux output is stable between read responses.
  assign w_mux = w_bank_rdata[r_p1_bank];

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_p2_valid;
      logic [DATA_W-1:0] r_resp_rdata;

      // Output register stage: capture the bank data only on a valid read.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          r_p2_valid   <= 1'b0;
          r_resp_rdata <= '0;
        end else begin
          r_p2_valid <= r_p1_valid;
          if (r_p1_valid) begin
            r_resp_rdata <= w_mux;
          end
        end
      end

      assign resp_valid = r_p2_valid;
      assign resp_rdata = r_resp_rdata;
    end else begin : g_lat1
      logic r_seen;

      // Remember that a read has completed since reset, so that before the
      // first response resp_rdata shows zero instead of unread bank registers.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          r_seen <= 1'b0;
        end else if (r_p1_valid) begin
          r_seen <= 1'b1;
        end
      end

      assign resp_valid = r_p1_valid;
      assign resp_rdata = (r_p1_valid || r_seen) ? w_mux : '0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_banked_1rw.sv
// Directed bench for sram_banked_1rw: one instance per read latency, both
// driven by the same request stream and checked against hand-computed values.
module tb_sram_banked_1rw;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam logic [DW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;

  logic          ready1, valid1, init1;
  logic [DW-1:0] rdata1;
  logic          ready2, valid2, init2;
  logic [DW-1:0] rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_banked_1rw #(
    .DATA_W(DW), .DEPTH(512), .BANKS(2), .RD_LAT(1), .INIT_ZERO(1)
  ) u_dut1 (
    .CLK(clk), .RSTN(rst_n),
    .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(valid1), .resp_rdata(rdata1), .init_done(init1)
  );

  sram_banked_1rw #(
    .DATA_W(DW), .DEPTH(512), .BANKS(2), .RD_LAT(2), .INIT_ZERO(1)
  ) u_dut2 (
    .CLK(clk), .RSTN(rst_n),
    .req_valid(req_valid), .req_ready(ready2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(valid2), .resp_rdata(rdata2), .init_done(init2)
  );

  typedef struct {
    string         name;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
  endtask

  // Count edges after reset release until init_done; ready must stay low meanwhile.
  task automatic wait_init(input string name);
    int cnt = 0;
    bit saw_ready = 1'b0;
    while (!init1 && cnt < 1000) begin
      step();
      cnt++;
      if (!init1 && (ready1 || ready2)) saw_ready = 1'b1;
    end
    idle();
    check({name, "_cycles"}, DW'(cnt), DW'(256));
    check({name, "_dut2_done"}, DW'(init2), DW'(1));
    check({name, "_no_ready"}, DW'(saw_ready), DW'(0));
  endtask

  // Issue one request; for reads check both latencies and the hold behaviour.
  task automatic run_vec(input vec_t v);
    drive(v.wr, v.addr, v.wdata, v.wmask);
    step();
    idle();
    if (v.wr) begin
      check({v.name, "_wr_noresp"}, DW'({valid1, valid2}), DW'(0));
    end else begin
      check({v.name, "_l1_valid"}, DW'({valid1, valid2}), DW'(2'b10));
      check({v.name, "_l1_data"}, rdata1, v.exp);
      step();
      check({v.name, "_l2_valid"}, DW'({valid1, valid2}), DW'(2'b01));
      check({v.name, "_l2_data"}, rdata2, v.exp);
      check({v.name, "_l1_hold"}, rdata1, v.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"rd_top",     1'b0, 9'h1FF, 64'h0, 64'h0, 64'h0};
    vecs[1]  = '{"rd_initwr",  1'b0, 9'h003, 64'h0, 64'h0, 64'h0};
    vecs[2]  = '{"wr5_full",   1'b1, 9'h005, 64'h0123_4567_89AB_CDEF, ONES, 64'h0};
    vecs[3]  = '{"wr5_mask",   1'b1, 9'h005, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000, 64'h0};
    vecs[4]  = '{"rd5",        1'b0, 9'h005, 64'h0, 64'h0, 64'h0123_4567_FFFF_CDEF};
    vecs[5]  = '{"wr6_full",   1'b1, 9'h006, 64'hAAAA_AAAA_AAAA_AAAA, ONES, 64'h0};
    vecs[6]  = '{"wr6_nomask", 1'b1, 9'h006, 64'h5555_5555_5555_5555, 64'h0, 64'h0};
    vecs[7]  = '{"rd6",        1'b0, 9'h006, 64'h0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[8]  = '{"wr100_hi",   1'b1, 9'h100, 64'hDEAD_BEEF_0000_1111, 64'hFFFF_FFFF_0000_0000, 64'h0};
    vecs[9]  = '{"rd100",      1'b0, 9'h100, 64'h0, 64'h0, 64'hDEAD_BEEF_0000_0000};
    vecs[10] = '{"rd4",        1'b0, 9'h004, 64'h0, 64'h0, 64'h0};
    vecs[11] = '{"rd5_again",  1'b0, 9'h005, 64'h0, 64'h0, 64'h0123_4567_FFFF_CDEF};

    rst_n     = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    idle();
    repeat (3) step();

    // Reset values.
    check("rst_ready",  DW'({ready1, ready2}), DW'(0));
    check("rst_valid",  DW'({valid1, valid2}), DW'(0));
    check("rst_rdata1", rdata1, DW'(0));
    check("rst_rdata2", rdata2, DW'(0));
    check("rst_init",   DW'({init1, init2}), DW'(0));

    // Init sweep with a write request held throughout; it must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 9'h003, ONES, ONES);
    wait_init("init");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 64'h1111_0000_0000_0000 + DW'(i), ONES);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, AW'(i), '0, '0);
      step();
      check($sformatf("b2b_l1_%0d", i), DW'(valid1), DW'(1));
      check($sformatf("b2b_l1_data_%0d", i), rdata1, 64'h1111_0000_0000_0000 + DW'(i));
      if (i == 0) begin
        check("b2b_l2_early", DW'(valid2), DW'(0));
      end else begin
        check($sformatf("b2b_l2_%0d", i - 1), DW'(valid2), DW'(1));
        check($sformatf("b2b_l2_data_%0d", i - 1), rdata2, 64'h1111_0000_0000_0000 + DW'(i - 1));
      end
    end
    idle();
    step();
    check("b2b_l1_end", DW'(valid1), DW'(0));
    check("b2b_l2_3", DW'(valid2), DW'(1));
    check("b2b_l2_data_3", rdata2, 64'h1111_0000_0000_0003);
    step();
    check("b2b_l2_end", DW'(valid2), DW'(0));
    check("b2b_l2_hold", rdata2, 64'h1111_0000_0000_0003);

    // Bank enables and read-after-write on consecutive cycles.
    #1;
    check("en_idle", DW'(u_dut1.w_bank_en), DW'(0));
    drive(1'b1, 9'h006, 64'h6666_6666_6666_6666, ONES);
    #1;
    check("en_wr6", DW'(u_dut1.w_bank_en), DW'(2'b01));
    step();
    drive(1'b1, 9'h007, 64'h7777_0000_7777_0000, ONES);
    #1;
    check("en_wr7", DW'(u_dut1.w_bank_en), DW'(2'b10));
    step();
    drive(1'b0, 9'h007, '0, '0);
    #1;
    check("en_rd7", DW'(u_dut1.w_bank_en), DW'(2'b10));
    step();
    idle();
    check("raw7_l1", rdata1, 64'h7777_0000_7777_0000);
    step();
    check("raw7_l2", rdata2, 64'h7777_0000_7777_0000);

    // Reset with reads in flight.
    drive(1'b0, 9'h005, '0, '0);
    step();
    drive(1'b0, 9'h100, '0, '0);
    step();
    rst_n = 1'b0;
    idle();
    #1;
    check("mid_rst_valid", DW'({valid1, valid2}), DW'(0));
    check("mid_rst_rdata2", rdata2, DW'(0));
    check("mid_rst_init", DW'({init1, init2, ready1, ready2}), DW'(0));
    begin
      bit stale = 1'b0;
      repeat (3) begin
        step();
        if (valid1 || valid2) stale = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) begin
        step();
        if (valid1 || valid2) stale = 1'b1;
      end
      check("mid_rst_no_stale", DW'(stale), DW'(0));
    end

    // Reset again during init row 100; sweep must restart from row 0.
    check("row100", DW'(u_dut1.r_init_row), DW'(100));
    rst_n = 1'b0;
    #1;
    check("row_cleared", DW'(u_dut1.r_init_row), DW'(0));
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");

    // Re-init wiped earlier data.
    begin
      vec_t v;
      v = '{"rd5_after_reinit", 1'b0, 9'h005, 64'h0, 64'h0, 64'h0};
      run_vec(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
